// File: rtl/s2mm_line_writer.sv
// rtl/s2mm_line_writer.sv - packs complex accumulator results into 128-bit S2MM beats through an 8-deep FWFT FIFO
// Optional feature macro: S2MM_DROP_CNT_EN (builds the saturating dropped-beat counter)
module s2mm_line_writer (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic [7:0]   frame_len,
  input  logic         sum_valid,
  input  logic [31:0]  sum_r,
  input  logic [31:0]  sum_i,
  output logic [127:0] S_AXIS_S2MM_tdata,
  output logic         S_AXIS_S2MM_tvalid,
  input  logic         S_AXIS_S2MM_tready,
  output logic         S_AXIS_S2MM_tlast,
  output logic [15:0]  S_AXIS_S2MM_tkeep,
  output logic         overflow,
  output logic [15:0]  drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} pack_state_e;

  pack_state_e  state_q;
  logic [63:0]  lane0_q;
  logic [127:0] mem_q [8];
  logic [2:0]   wr_ptr_q;
  logic [2:0]   rd_ptr_q;
  logic [3:0]   count_q;
  logic [3:0]   count_d;
  logic [7:0]   beat_cnt_q;
  logic         overflow_q;

  logic         beat_done;
  logic [127:0] beat_data;
  logic         full;
  logic         pop;
  logic         push;
  logic         drop;
  logic         is_last;

  // A beat completes on the second result; it enters the FIFO if there is room
  // or if the head is leaving in the same cycle.
  assign beat_done = sum_valid && (state_q == HALF);
  assign beat_data = {sum_i, sum_r, lane0_q};
  assign full      = (count_q == 4'd8);
  assign pop       = S_AXIS_S2MM_tvalid && S_AXIS_S2MM_tready;
  assign push      = beat_done && (!full || pop);
  assign drop      = beat_done && full && !pop;
  // frame_len of 0 wraps to 255 here, giving a 256-beat frame.
  assign is_last   = (beat_cnt_q == (frame_len - 8'd1));

  assign S_AXIS_S2MM_tvalid = (count_q != 4'd0);
  assign S_AXIS_S2MM_tdata  = S_AXIS_S2MM_tvalid ? mem_q[rd_ptr_q] : 128'h0;
  assign S_AXIS_S2MM_tlast  = S_AXIS_S2MM_tvalid && is_last;
  assign S_AXIS_S2MM_tkeep  = 16'hFFFF;
  assign overflow           = overflow_q;

  // Packer FSM: the first result of a pair parks in lane 0, the second completes the beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      lane0_q <= 64'h0;
    end else if (clr) begin
      state_q <= EMPTY;
    end else if (sum_valid) begin
      case (state_q)
        EMPTY: begin
          lane0_q <= {sum_i, sum_r};
          state_q <= HALF;
        end
        HALF:    state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  // FIFO storage; contents are only visible through tdata while an entry is valid.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_q[wr_ptr_q] <= beat_data;
    end
  end

  // Occupancy next-state: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else if (clr) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 3'd1;
      count_q <= count_d;
    end
  end

  // Beat-in-frame counter advances only on handshaken beats and wraps after tlast.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_q <= 8'd0;
    end else if (clr) begin
      beat_cnt_q <= 8'd0;
    end else if (pop) begin
      beat_cnt_q <= is_last ? 8'd0 : beat_cnt_q + 8'd1;
    end
  end

  // Sticky overflow flag, raised whenever a completed beat is discarded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
    end else if (clr) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef S2MM_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of discarded beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_q <= 16'h0000;
    end else if (clr) begin
      drop_cnt_q <= 16'h0000;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_s2mm_line_writer.sv
// tb/tb_s2mm_line_writer.sv - directed self-checking bench for s2mm_line_writer
module tb_s2mm_line_writer;

  logic         clk;
  logic         rstn;
  logic         clr;
  logic [7:0]   frame_len;
  logic         sum_valid;
  logic [31:0]  sum_r;
  logic [31:0]  sum_i;
  logic [127:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [15:0]  tkeep;
  logic         overflow;
  logic [15:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [128:0] mon_q[$];
  logic [127:0] exp_q[$];
  logic [63:0]  half_l;
  bit           have_half;
  logic [15:0]  seq;

`ifdef S2MM_DROP_CNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd2;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  s2mm_line_writer dut (
    .clk                (clk),
    .rstn               (rstn),
    .clr                (clr),
    .frame_len          (frame_len),
    .sum_valid          (sum_valid),
    .sum_r              (sum_r),
    .sum_i              (sum_i),
    .S_AXIS_S2MM_tdata  (tdata),
    .S_AXIS_S2MM_tvalid (tvalid),
    .S_AXIS_S2MM_tready (tready),
    .S_AXIS_S2MM_tlast  (tlast),
    .S_AXIS_S2MM_tkeep  (tkeep),
    .overflow           (overflow),
    .drop_cnt           (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn && !clr && tvalid && tready) mon_q.push_back({tlast, tdata});
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    have_half = 1'b0;
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic send_result(input logic [31:0] r, input logic [31:0] i);
    sum_valid = 1'b1;
    sum_r     = r;
    sum_i     = i;
    if (have_half) begin
      exp_q.push_back({i, r, half_l});
      have_half = 1'b0;
    end else begin
      half_l    = {i, r};
      have_half = 1'b1;
    end
    @(posedge clk);
    #1;
    sum_valid = 1'b0;
  endtask

  task automatic send_next();
    seq = seq + 16'd1;
    send_result({16'hA5A5, seq}, {16'h5A5A, seq});
  endtask

  task automatic test_reset();
    rstn = 1'b0; clr = 1'b0; sum_valid = 1'b0; sum_r = '0; sum_i = '0;
    tready = 1'b0; frame_len = 8'd1; seq = 16'd0;
    model_reset();
    wait_cycles(3);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%0b exp=0", tvalid); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%0b exp=0", tlast); end
    checks++; if (tdata !== 128'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt got=%h exp=0", drop_cnt); end
    checks++; if (tkeep !== 16'hFFFF) begin errors++; $display("FAIL reset_tkeep got=%h exp=ffff", tkeep); end
    rstn = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_single_beat();
    model_reset();
    frame_len = 8'd1;
    tready    = 1'b1;
    send_result(32'd1, 32'd2);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL single_early_tvalid got=%0b exp=0", tvalid); end
    send_result(32'd3, 32'd4);
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid got=%0b exp=1", tvalid); end
    checks++; if (tdata !== 128'h00000004_00000003_00000002_00000001) begin
      errors++; $display("FAIL single_tdata got=%h exp=00000004000000030000000200000001", tdata); end
    checks++; if (tlast !== 1'b1) begin errors++; $display("FAIL single_tlast got=%0b exp=1", tlast); end
    wait_cycles(1);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL single_drained got=%0b exp=0", tvalid); end
    checks++; if (mon_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", mon_q.size()); end
  endtask

  task automatic test_frame_wrap();
    model_reset();
    frame_len = 8'd4;
    tready    = 1'b1;
    for (int k = 0; k < 16; k++) send_next();
    wait_cycles(4);
    checks++; if (mon_q.size() != 8) begin errors++; $display("FAIL wrap_count got=%0d exp=8", mon_q.size()); end
    for (int j = 0; j < 8 && j < mon_q.size(); j++) begin
      checks++; if (mon_q[j][127:0] !== exp_q[j]) begin
        errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", j, mon_q[j][127:0], exp_q[j]); end
      checks++; if (mon_q[j][128] !== ((j % 4) == 3)) begin
        errors++; $display("FAIL wrap_tlast[%0d] got=%0b exp=%0b", j, mon_q[j][128], (j % 4) == 3); end
    end
  endtask

  task automatic test_backpressure();
    model_reset();
    frame_len = 8'd4;
    tready    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send_next();
      if (k >= 1) begin
        checks++; if (tvalid !== 1'b1 || tdata !== exp_q[0]) begin
          errors++; $display("FAIL bp_hold[%0d] got=%0b/%h exp=1/%h", k, tvalid, tdata, exp_q[0]); end
      end
    end
    for (int k = 0; k < 2; k++) begin
      wait_cycles(1);
      checks++; if (tvalid !== 1'b1 || tdata !== exp_q[0]) begin
        errors++; $display("FAIL bp_idle[%0d] got=%0b/%h exp=1/%h", k, tvalid, tdata, exp_q[0]); end
    end
    tready = 1'b1;
    wait_cycles(6);
    checks++; if (mon_q.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", mon_q.size()); end
    for (int j = 0; j < 4 && j < mon_q.size(); j++) begin
      checks++; if (mon_q[j] !== {(j == 3), exp_q[j]}) begin
        errors++; $display("FAIL bp_beat[%0d] got=%h exp=%h", j, mon_q[j], {(j == 3), exp_q[j]}); end
    end
  endtask

  task automatic test_overflow();
    model_reset();
    frame_len = 8'd4;
    tready    = 1'b0;
    for (int k = 0; k < 20; k++) send_next();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    checks++; if (drop_cnt !== EXP_DROPS) begin errors++; $display("FAIL ovf_drop_cnt got=%0d exp=%0d", drop_cnt, EXP_DROPS); end
    tready = 1'b1;
    wait_cycles(12);
    checks++; if (mon_q.size() != 8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", mon_q.size()); end
    for (int j = 0; j < 8 && j < mon_q.size(); j++) begin
      checks++; if (mon_q[j] !== {((j % 4) == 3), exp_q[j]}) begin
        errors++; $display("FAIL ovf_beat[%0d] got=%h exp=%h", j, mon_q[j], {((j % 4) == 3), exp_q[j]}); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
  endtask

  task automatic test_full_pop();
    clr = 1'b1;
    wait_cycles(1);
    clr = 1'b0;
    model_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_clr_overflow got=%0b exp=0", overflow); end
    checks++; if (drop_cnt !== 16'h0) begin errors++; $display("FAIL fp_clr_drop_cnt got=%0d exp=0", drop_cnt); end
    frame_len = 8'd4;
    tready    = 1'b0;
    for (int k = 0; k < 17; k++) send_next();
    tready = 1'b1;
    send_next();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow got=%0b exp=0", overflow); end
    wait_cycles(12);
    checks++; if (mon_q.size() != 9) begin errors++; $display("FAIL fp_count got=%0d exp=9", mon_q.size()); end
    for (int j = 0; j < 9 && j < mon_q.size(); j++) begin
      checks++; if (mon_q[j] !== {((j % 4) == 3), exp_q[j]}) begin
        errors++; $display("FAIL fp_beat[%0d] got=%h exp=%h", j, mon_q[j], {((j % 4) == 3), exp_q[j]}); end
    end
  endtask

  task automatic test_clear();
    model_reset();
    frame_len = 8'd1;
    tready    = 1'b1;
    send_result(32'hDEAD0001, 32'hDEAD0002);
    // clr together with sum_valid: the result under clr must also vanish
    clr = 1'b1; sum_valid = 1'b1; sum_r = 32'hBEEF0001; sum_i = 32'hBEEF0002;
    wait_cycles(1);
    clr = 1'b0; sum_valid = 1'b0;
    send_result(32'd5, 32'd6);
    send_result(32'd7, 32'd8);
    wait_cycles(3);
    checks++; if (mon_q.size() != 1) begin errors++; $display("FAIL clr_count got=%0d exp=1", mon_q.size()); end
    if (mon_q.size() > 0) begin
      checks++; if (mon_q[0] !== {1'b1, 128'h00000008_00000007_00000006_00000005}) begin
        errors++; $display("FAIL clr_beat got=%h exp=1_00000008000000070000000600000005", mon_q[0]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    model_reset();
    frame_len = 8'd4;
    tready    = 1'b1;
    send_next();
    send_next();
    wait_cycles(2);
    tready = 1'b0;
    for (int k = 0; k < 5; k++) send_next();
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL rst_pre_tvalid got=%0b exp=1", tvalid); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_async_tvalid got=%0b exp=0", tvalid); end
    checks++; if (tdata !== 128'h0) begin errors++; $display("FAIL rst_async_tdata got=%h exp=0", tdata); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    frame_len = 8'd1;
    tready    = 1'b1;
    send_result(32'h11, 32'h22);
    send_result(32'h33, 32'h44);
    wait_cycles(3);
    checks++; if (mon_q.size() != 1) begin errors++; $display("FAIL rst_count got=%0d exp=1", mon_q.size()); end
    if (mon_q.size() > 0) begin
      checks++; if (mon_q[0] !== {1'b1, 128'h00000044_00000033_00000022_00000011}) begin
        errors++; $display("FAIL rst_beat got=%h exp=1_00000044000000330000002200000011", mon_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_frame_wrap();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_clear();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s2mm_line_writer.md
S2MM_LINE_WRITER -- requirements
Module: s2mm_line_writer

Interface
REQ-001 SHALL provide: clk  in  1  rising-edge clock for all logic.
REQ-002 SHALL provide: rstn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: clr  in  1  synchronous clear of the packer, FIFO, beat counter, overflow and drop_cnt.
REQ-004 SHALL provide: frame_len  in  8  beats per frame; 0 means 256.
REQ-005 SHALL provide: sum_valid  in  1  qualifies one complex accumulator result per cycle.
REQ-006 SHALL provide: sum_r  in  32  real accumulator result.
REQ-007 SHALL provide: sum_i  in  32  imaginary accumulator result.
REQ-008 SHALL provide: S_AXIS_S2MM_tdata  out  128  packed results toward the DMA S2MM channel.
REQ-009 SHALL provide: S_AXIS_S2MM_tvalid  out  1  beat valid.
REQ-010 SHALL provide: S_AXIS_S2MM_tready  in  1  DMA accepts beat.
REQ-011 SHALL provide: S_AXIS_S2MM_tlast  out  1  last beat of frame.
REQ-012 SHALL provide: S_AXIS_S2MM_tkeep  out  16  byte enables.
REQ-013 SHALL provide: overflow  out  1  sticky, set when a beat is dropped.
REQ-014 SHALL provide: drop_cnt  out  16  dropped-beat count.

Function
REQ-015 The packer SHALL be an FSM with states EMPTY and HALF: in EMPTY, sum_valid stores {sum_i,sum_r} into lane [63:0] and moves to HALF; in HALF, sum_valid stores {sum_i,sum_r} into lane [127:64], completes the beat, and returns to EMPTY.
REQ-016 Within each lane, sum_r SHALL occupy the low 32 bits and sum_i the high 32 bits.
REQ-017 A completed beat SHALL be written into an 8-deep first-word-fall-through FIFO at the clock edge that samples the second result.
REQ-018 With the FIFO empty, tvalid SHALL assert in the cycle after that edge, giving a latency of 1 cycle.
REQ-019 tvalid SHALL equal FIFO-not-empty; a beat SHALL pop only on tvalid && tready.
REQ-020 While tvalid=1 and tready=0, tdata and tlast SHALL remain stable, and tvalid SHALL NOT deassert except on rstn or clr.
REQ-021 If a beat completes while the FIFO is full and no pop occurs that cycle, the beat SHALL be dropped, overflow SHALL be set, and the drop counter SHALL increment.
REQ-022 A simultaneous push and pop when full SHALL be accepted, with the count unchanged.
REQ-023 An 8-bit beat counter SHALL count handshaken beats; tlast SHALL be 1 when counter == frame_len-1 (mod 256).
REQ-024 The beat counter SHALL wrap to 0 on the tlast handshake; dropped beats SHALL NOT advance it.
REQ-025 tkeep SHALL be constant 16'hFFFF.
REQ-026 frame_len SHALL be sampled combinationally each cycle; software changes it only when the FIFO is empty and the counter is 0.
REQ-027 clr SHALL take priority over a sum_valid or handshake in the same cycle.
REQ-028 clr SHALL discard a HALF beat and set FSM=EMPTY, FIFO empty, counter=0, overflow=0, drop_cnt=0.

Reset
REQ-029 On rstn low, all of the following SHALL be set asynchronously: FSM=EMPTY, FIFO pointers=0, beat counter=0, tvalid=0, tlast=0, tdata=0, overflow=0, drop_cnt=0.
REQ-030 Reset mid-frame SHALL abandon the frame; the first beat after reset SHALL be counter 0.

Configuration
REQ-031 With macro S2MM_DROP_CNT_EN defined, drop_cnt SHALL be a 16-bit counter that saturates at 16'hFFFF.
REQ-032 Without S2MM_DROP_CNT_EN, drop_cnt SHALL be tied to 16'h0000 and no counter SHALL be built; overflow behaviour SHALL be unchanged.

Verification
REQ-033 Single beat: frame_len=1, tready=1, sum_valid on two consecutive cycles with (r,i)=(1,2) then (3,4) -> one beat, tdata=128'h00000004_00000003_00000002_00000001, tlast=1, tvalid 1 cycle after the second sample.
REQ-034 Frame wrap: frame_len=4, 16 results with tready=1 -> 8 beats, tlast on beats 4 and 8 only.
REQ-035 Backpressure: tready=0 for 10 cycles while 4 beats complete -> tvalid held, tdata unchanged; on release, 4 beats in order with no loss.
REQ-036 Overflow: tready=0, 20 results (10 beats) -> 8 stored, overflow=1, drop_cnt=2 (0 without macro); release -> the first 8 beats output.
REQ-037 Clear/reset: one result (HALF), then clr -> next two results form beat 0 with lane0 = the first post-clr result; rstn pulse mid-frame -> tvalid=0 immediately, counter 0.
REQ-038 Full+pop: FIFO full, tready=1 in the same cycle a beat completes -> no drop, overflow stays 0.
